// File: rtl/charging_station_pkg.sv
// Shared coin codes, credit table and time limit for the charging-station timer.
package charging_station_pkg;

    localparam int MAX_SECONDS_DEFAULT = 599;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        COIN_1    = 3'd1,
        COIN_2    = 3'd2,
        COIN_3    = 3'd3,
        COIN_4    = 3'd4
    } coin_e;

    // Codes 5..7 are not valid coins and earn nothing.
    function automatic logic [9:0] coin_credit(input logic [2:0] code);
        case (code)
            COIN_1:  return 10'd30;
            COIN_2:  return 10'd60;
            COIN_3:  return 10'd120;
            COIN_4:  return 10'd300;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/charging_station_bcd.sv
// Combinational binary seconds (0..599) to BCD M:SS for the display driver.
module secs_to_bcd_mss (
    input  logic [9:0]  i_secs,
    output logic [11:0] o_bcd
);
    logic [3:0] w_min;
    logic [3:0] w_tens;
    logic [3:0] w_units;
    logic [9:0] w_rem;

    // Threshold chains instead of dividers; the input range is small and fixed.
    always_comb begin
        w_min = '0;
        for (int unsigned m = 1; m < 10; m++) begin
            if (i_secs >= 10'(m * 60)) w_min = 4'(m);
        end
        w_rem  = i_secs - 10'(w_min) * 10'd60;
        w_tens = '0;
        for (int unsigned t = 1; t < 6; t++) begin
            if (w_rem >= 10'(t * 10)) w_tens = 4'(t);
        end
        w_units = 4'(w_rem - 10'(w_tens) * 10'd10);
    end

    assign o_bcd = {w_min, w_tens, w_units};

endmodule

// File: rtl/charging_station.sv
// Coin-operated charging timer: edge-detected coin credit, prescaled countdown, BCD M:SS output.
module charging_station
    import charging_station_pkg::*;
#(
    parameter int TICK_DIV    = 10,
    parameter int MAX_SECONDS = MAX_SECONDS_DEFAULT
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic [2:0]  Coin,
    output logic [11:0] PresentTime
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [9:0]    r_secs;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_coin_q;

    logic          w_accept;
    logic          w_tick;
    logic [9:0]    w_credit;
    logic [10:0]   w_sum;
    logic [9:0]    w_sat;
    logic [9:0]    w_secs_next;
    logic [PW-1:0] w_presc_next;

    assign w_accept = Enable && (Coin != COIN_NONE) && (r_coin_q == COIN_NONE);
    assign w_tick   = Enable && (r_secs != '0) && (r_presc == PW'(TICK_DIV - 1));
    assign w_credit = w_accept ? coin_credit(Coin) : '0;

    // Clamp before the tick decrement so a coin landing on a tick at the limit still counts down.
    always_comb begin
        w_sum       = {1'b0, r_secs} + {1'b0, w_credit};
        w_sat       = (w_sum > 11'(MAX_SECONDS)) ? 10'(MAX_SECONDS) : w_sum[9:0];
        w_secs_next = w_sat - {9'd0, w_tick};
    end

    always_comb begin
        w_presc_next = r_presc;
        if (Enable) begin
            if (r_secs == '0)
                w_presc_next = '0;
            else if (r_presc == PW'(TICK_DIV - 1))
                w_presc_next = '0;
            else
                w_presc_next = r_presc + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_secs   <= '0;
            r_presc  <= '0;
            r_coin_q <= '0;
        end else begin
            r_coin_q <= Coin;
            r_presc  <= w_presc_next;
            if (Enable) r_secs <= w_secs_next;
        end
    end

    secs_to_bcd_mss u_bcd (
        .i_secs (r_secs),
        .o_bcd  (PresentTime)
    );

endmodule

// File: tb/tb_charging_station.sv
// Directed-vector bench for charging_station (TICK_DIV=10, 10 ns clock).
module tb_charging_station;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Enable;
    logic [2:0]  Coin;
    logic [11:0] PresentTime;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic [2:0]  coin;
        int unsigned n;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    charging_station #(.TICK_DIV(10), .MAX_SECONDS(599)) dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .Enable      (Enable),
        .Coin        (Coin),
        .PresentTime (PresentTime)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (PresentTime !== exp) begin
            failures++;
            $display("FAIL %s: PresentTime=%h expected=%h", name, PresentTime, exp);
        end
    endtask

    task automatic add(input logic en, input logic [2:0] coin, input int unsigned n,
                       input logic [11:0] exp, input string name);
        vec_t v;
        v.en = en; v.coin = coin; v.n = n; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        nReset = 1'b0;
        Enable = 1'b0;
        Coin   = 3'd0;

        // Hand-computed trace: secs / prescaler noted per vector.
        add(1, 1, 1,  12'h030, "coin1_credit");       // 30 s, p=0
        add(1, 1, 9,  12'h030, "coin1_held_no_tick"); // p=9
        add(1, 1, 1,  12'h029, "first_tick");         // 29, p=0
        add(1, 0, 1,  12'h029, "coin_release");       // p=1
        add(1, 2, 1,  12'h129, "coin2_credit");       // 89, p=2
        add(1, 0, 1,  12'h129, "coin2_release");      // p=3
        add(1, 3, 1,  12'h329, "coin3_credit");       // 209, p=4
        add(1, 3, 1,  12'h329, "coin3_held");         // p=5
        add(1, 2, 1,  12'h329, "nonzero_change");     // p=6
        add(1, 0, 1,  12'h329, "release_a");          // p=7
        add(1, 5, 1,  12'h329, "invalid5");           // p=8
        add(1, 0, 1,  12'h329, "release_b");          // p=9
        add(1, 6, 1,  12'h328, "invalid6_tick");      // 208, p=0
        add(1, 0, 1,  12'h328, "release_c");          // p=1
        add(1, 7, 1,  12'h328, "invalid7");           // p=2
        add(1, 0, 1,  12'h328, "release_d");          // p=3
        add(1, 4, 1,  12'h828, "coin4_credit");       // 508, p=4
        add(1, 0, 1,  12'h828, "release_e");          // p=5
        add(1, 4, 1,  12'h959, "saturate");           // 599, p=6
        add(1, 0, 1,  12'h959, "release_f");          // p=7
        add(1, 4, 1,  12'h959, "saturate_again");     // p=8
        add(1, 0, 1,  12'h959, "release_g");          // p=9
        add(1, 1, 1,  12'h958, "sat_then_tick");      // 598, p=0
        add(1, 0, 1,  12'h958, "release_h");          // p=1
        add(0, 0, 50, 12'h958, "frozen_50");          // frozen, p=1
        add(0, 2, 1,  12'h958, "coin_while_off");
        add(0, 2, 5,  12'h958, "coin_held_off");
        add(1, 2, 1,  12'h958, "held_across_enable"); // p=2
        add(1, 0, 7,  12'h958, "resume_no_tick");     // p=9
        add(1, 0, 1,  12'h957, "resume_tick");        // 597, p=0

        #3;
        check("reset_state", 12'h000);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            Enable = vecs[i].en;
            Coin   = vecs[i].coin;
            repeat (vecs[i].n) @(posedge Clk);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset between edges while counting down.
        @(negedge Clk);
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset", 12'h000);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b1;
        Enable = 1'b1;
        Coin   = 3'd0;
        @(posedge Clk);
        #1;
        check("after_reset", 12'h000);

        // Countdown to zero from 0:30.
        @(negedge Clk);
        Coin = 3'd1;
        @(posedge Clk);
        #1;
        check("zero_load", 12'h030);
        @(negedge Clk);
        Coin = 3'd0;
        repeat (299) @(posedge Clk);
        #1;
        check("one_left", 12'h001);
        @(posedge Clk);
        #1;
        check("reach_zero", 12'h000);
        repeat (23) @(posedge Clk);
        #1;
        check("hold_zero", 12'h000);

        // Prescaler must have been idle at zero: first tick exactly 10 edges after reload.
        @(negedge Clk);
        Coin = 3'd1;
        @(posedge Clk);
        #1;
        check("reload", 12'h030);
        @(negedge Clk);
        Coin = 3'd0;
        repeat (9) @(posedge Clk);
        #1;
        check("reload_no_tick", 12'h030);
        @(posedge Clk);
        #1;
        check("reload_tick", 12'h029);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
